// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with either saturating or modulo (MAX_VAL+1) limit handling.
// ovf/unf/sat_hit are registered one-cycle pulses; the done flags decode the count register.
module updown_counter_param #(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter bit WRAP    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cntU,
  input  logic             cntD,
  output logic [WIDTH-1:0] result,
  output logic             down_done,
  output logic             up_done,
  output logic             ovf,
  output logic             unf,
  output logic             sat_hit
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_r;
  logic             ovf_r;
  logic             unf_r;
  logic             sat_r;

  logic [WIDTH-1:0] count_nxt_s;
  logic             ovf_nxt_s;
  logic             unf_nxt_s;
  logic             sat_nxt_s;
  logic [WIDTH:0]   count_ext_s;
  logic [WIDTH:0]   load_ext_s;
  logic [WIDTH:0]   inc_s;
  logic [WIDTH:0]   dec_s;

  // One extra bit keeps the carry out of +1 and the borrow out of -1 visible.
  assign count_ext_s = {1'b0, count_r};
  assign load_ext_s  = {1'b0, load_val};
  assign inc_s       = count_ext_s + ONE_EXT;
  assign dec_s       = count_ext_s - ONE_EXT;

  // Next count and event flags, in priority order clr > load > both > up > down.
  always_comb begin
    count_nxt_s = count_r;
    ovf_nxt_s   = 1'b0;
    unf_nxt_s   = 1'b0;
    sat_nxt_s   = 1'b0;
    if (clr) begin
      count_nxt_s = ZERO;
    end else if (load) begin
      if (load_ext_s > MAX_EXT) begin
        count_nxt_s = MAX_CNT;
      end else begin
        count_nxt_s = load_val;
      end
    end else if (cntU && cntD) begin
      count_nxt_s = count_r;
    end else if (cntU) begin
      if (inc_s > MAX_EXT) begin
        if (WRAP) begin
          count_nxt_s = ZERO;
          ovf_nxt_s   = 1'b1;
        end else begin
          count_nxt_s = count_r;
          sat_nxt_s   = 1'b1;
        end
      end else begin
        count_nxt_s = inc_s[WIDTH-1:0];
      end
    end else if (cntD) begin
      if (dec_s[WIDTH]) begin
        if (WRAP) begin
          count_nxt_s = MAX_CNT;
          unf_nxt_s   = 1'b1;
        end else begin
          count_nxt_s = count_r;
          sat_nxt_s   = 1'b1;
        end
      end else begin
        count_nxt_s = dec_s[WIDTH-1:0];
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count and pulse registers; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= ZERO;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
      sat_r   <= sat_nxt_s;
    end
  end

  assign result    = count_r;
  assign down_done = (count_r == ZERO);
  assign up_done   = (count_r == MAX_CNT);
  assign ovf       = WRAP ? ovf_r : 1'b0;
  assign unf       = WRAP ? unf_r : 1'b0;
  assign sat_hit   = WRAP ? 1'b0  : sat_r;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations driven by shared stimulus,
// checked every cycle against an arithmetic reference model.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       load;
  logic       cnt_u;
  logic       cnt_d;
  logic [4:0] lv5;
  logic [3:0] lv4;

  logic [4:0] res_a;
  logic [3:0] res_b;
  logic [3:0] res_c;
  logic dd_a, ud_a, ovf_a, unf_a, sat_a;
  logic dd_b, ud_b, ovf_b, unf_b, sat_b;
  logic dd_c, ud_c, ovf_c, unf_c, sat_c;

  assign lv4 = lv5[3:0];

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(5)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv5), .cntU(cnt_u), .cntD(cnt_d),
    .result(res_a), .down_done(dd_a), .up_done(ud_a), .ovf(ovf_a), .unf(unf_a), .sat_hit(sat_a));

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .WRAP(1'b1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv4), .cntU(cnt_u), .cntD(cnt_d),
    .result(res_b), .down_done(dd_b), .up_done(ud_b), .ovf(ovf_b), .unf(unf_b), .sat_hit(sat_b));

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .WRAP(1'b0)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv4), .cntU(cnt_u), .cntD(cnt_d),
    .result(res_c), .down_done(dd_c), .up_done(ud_c), .ovf(ovf_c), .unf(unf_c), .sat_hit(sat_c));

  int n_checks = 0;
  int n_errors = 0;

  int mx[3] = '{31, 9, 9};
  bit wr[3] = '{1'b0, 1'b1, 1'b0};
  int cnt[3];
  bit e_ovf[3];
  bit e_unf[3];
  bit e_sat[3];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i]   = 0;
      e_ovf[i] = 1'b0;
      e_unf[i] = 1'b0;
      e_sat[i] = 1'b0;
    end
  endtask

  // Reference behaviour stated directly in integer arithmetic.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int lv;
      lv = (i == 0) ? int'(lv5) : int'(lv4);
      e_ovf[i] = 1'b0;
      e_unf[i] = 1'b0;
      e_sat[i] = 1'b0;
      if (clr) begin
        cnt[i] = 0;
      end else if (load) begin
        cnt[i] = (lv > mx[i]) ? mx[i] : lv;
      end else if (cnt_u && cnt_d) begin
        cnt[i] = cnt[i];
      end else if (cnt_u) begin
        if (cnt[i] == mx[i]) begin
          if (wr[i]) begin
            cnt[i]   = (cnt[i] + 1) % (mx[i] + 1);
            e_ovf[i] = 1'b1;
          end else begin
            e_sat[i] = 1'b1;
          end
        end else begin
          cnt[i] = cnt[i] + 1;
        end
      end else if (cnt_d) begin
        if (cnt[i] == 0) begin
          if (wr[i]) begin
            cnt[i]   = (cnt[i] - 1 + mx[i] + 1) % (mx[i] + 1);
            e_unf[i] = 1'b1;
          end else begin
            e_sat[i] = 1'b1;
          end
        end else begin
          cnt[i] = cnt[i] - 1;
        end
      end
    end
  endtask

  task automatic check_inst(input string nm, input int i, input logic [31:0] r,
                            input logic dd, input logic ud, input logic ov,
                            input logic un, input logic sh);
    check_value({nm, ".result"},    r,          32'(cnt[i]));
    check_value({nm, ".down_done"}, 32'(dd),    32'(cnt[i] == 0));
    check_value({nm, ".up_done"},   32'(ud),    32'(cnt[i] == mx[i]));
    check_value({nm, ".ovf"},       32'(ov),    32'(e_ovf[i]));
    check_value({nm, ".unf"},       32'(un),    32'(e_unf[i]));
    check_value({nm, ".sat_hit"},   32'(sh),    32'(e_sat[i]));
  endtask

  task automatic check_all();
    check_inst("A", 0, 32'(res_a), dd_a, ud_a, ovf_a, unf_a, sat_a);
    check_inst("B", 1, 32'(res_b), dd_b, ud_b, ovf_b, unf_b, sat_b);
    check_inst("C", 2, 32'(res_c), dd_c, ud_c, ovf_c, unf_c, sat_c);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic c, input logic l, input logic u, input logic d, input int v);
    clr   = c;
    load  = l;
    cnt_u = u;
    cnt_d = d;
    lv5   = 5'(v);
  endtask

  // Pulls reset low between edges and checks the asynchronous response.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    check_value("rst.result_a", 32'(res_a), 32'd0);
    check_value("rst.up_done_a", 32'(ud_a), 32'd0);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    model_reset();
    #1;
    check_all();
    check_value("reset.down_done_a", 32'(dd_a), 32'd1);
    #2;
    rst = 1'b1;

    // Climb to the limit and keep pushing: saturate in A, wrap in B.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k == 31) check_value("climb.result_31", 32'(res_a), 32'd31);
      if (k >= 32) check_value("climb.sat_pulse", 32'(sat_a), 32'd1);
    end
    check_value("climb.up_done", 32'(ud_a), 32'd1);

    // Count down from 1 into the floor.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0);
    tick();
    check_value("floor.result", 32'(res_a), 32'd0);
    tick();
    check_value("floor.sat", 32'(sat_a), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick();
    check_value("floor.sat_clear", 32'(sat_a), 32'd0);

    // Non-power-of-two wrap: ten ups from 0 reach 9 then 0, one ovf; then down wraps to 9.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 9)  check_value("wrap.result_9", 32'(res_b), 32'd9);
      if (k == 10) check_value("wrap.ovf", 32'(ovf_b), 32'd1);
    end
    check_value("wrap.result_0", 32'(res_b), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0);
    tick();
    check_value("wrap.unf", 32'(unf_b), 32'd1);
    check_value("wrap.result_down", 32'(res_b), 32'd9);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick();
    check_value("wrap.unf_clear", 32'(unf_b), 32'd0);

    // Priority: clr beats load and cntU; load clamps above MAX_VAL.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 7);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3);
    tick();
    check_value("prio.clr", 32'(res_a), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 15);
    tick();
    check_value("prio.clamp", 32'(res_b), 32'd9);
    check_value("prio.noclamp", 32'(res_a), 32'd15);

    // Simultaneous up and down holds without pulses.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 0);
    for (int k = 0; k < 3; k++) tick();
    check_value("both.hold", 32'(res_a), 32'd12);

    // Asynchronous reset mid-count, then resume from 0.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 20);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
    async_reset();
    tick();
    check_value("resume.result", 32'(res_a), 32'd1);

    // Randomized traffic with occasional async resets.
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 31)));
      tick();
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 Parameter WIDTH, default 5, SHALL set the count width in bits; legal range 2..16.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1, SHALL set the upper count limit; legal range 1..2**WIDTH-1.
REQ-003 Parameter WRAP, default 0, SHALL select the limit mode: 0 = saturate at limits, 1 = modulo (MAX_VAL+1) wrap.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset; it is asynchronous and active-low.
REQ-006 Port clr, input, 1 bit, SHALL request a synchronous clear of the count to 0.
REQ-007 Port load, input, 1 bit, SHALL request a synchronous load of load_val.
REQ-008 Port load_val, input, WIDTH bits, SHALL supply the value to load.
REQ-009 Port cntU, input, 1 bit, SHALL request an increment by 1.
REQ-010 Port cntD, input, 1 bit, SHALL request a decrement by 1.
REQ-011 Port result, output, WIDTH bits, SHALL present the registered count.
REQ-012 Port down_done, output, 1 bit, SHALL be high whenever result == 0 (combinational from the count register).
REQ-013 Port up_done, output, 1 bit, SHALL be high whenever result == MAX_VAL (combinational from the count register).
REQ-014 Port ovf, output, 1 bit, SHALL pulse high for exactly one cycle after a wrap from MAX_VAL to 0.
REQ-015 Port unf, output, 1 bit, SHALL pulse high for exactly one cycle after a wrap from 0 to MAX_VAL.
REQ-016 Port sat_hit, output, 1 bit, SHALL pulse high for exactly one cycle after a count request blocked by saturation.

Function
REQ-017 Per-edge priority SHALL be: clr > load > (cntU and cntD both high: hold) > cntU > cntD > hold.
REQ-018 clr SHALL set the count to 0 on the next edge and SHALL NOT assert ovf, unf or sat_hit.
REQ-019 load SHALL set the count to load_val, clamped to MAX_VAL when load_val > MAX_VAL, with no flag pulses.
REQ-020 When cntU and cntD are both high (no clr/load), the count SHALL hold and no pulse SHALL be asserted.
REQ-021 cntU alone with count < MAX_VAL SHALL increment the count by 1 on the next edge; latency is one cycle.
REQ-022 cntD alone with count > 0 SHALL decrement the count by 1 on the next edge.
REQ-023 WRAP=0: cntU at MAX_VAL or cntD at 0 SHALL leave the count unchanged and pulse sat_hit on the next cycle.
REQ-024 WRAP=1: cntU at MAX_VAL SHALL load 0 and pulse ovf; cntD at 0 SHALL load MAX_VAL and pulse unf.
REQ-025 sat_hit SHALL be tied 0 when WRAP=1; ovf and unf SHALL be tied 0 when WRAP=0.
REQ-026 ovf, unf and sat_hit SHALL be registered and SHALL be low on any cycle without a qualifying event; continuous requests at a limit produce one pulse per edge.
REQ-027 Arithmetic SHALL be performed in WIDTH+1 bits internally so that no carry or borrow is lost; result SHALL never exceed MAX_VAL.
REQ-028 The count SHALL never take a value outside 0..MAX_VAL, including non-power-of-two MAX_VAL.

Reset
REQ-029 Asserting rst low SHALL immediately force result=0, ovf=0, unf=0 and sat_hit=0, regardless of clk.
REQ-030 During reset, down_done SHALL be 1 and up_done SHALL be 0.
REQ-031 Reset asserted mid-count SHALL discard the in-flight request; after deassertion, counting SHALL resume from 0 on the first rising edge with rst high.
REQ-032 Reset deassertion SHALL be treated as synchronous to clk by the integrating design; the block adds no synchroniser.

Verification
REQ-033 Scenario: WIDTH=5, WRAP=0; reset, then 33 cycles of cntU -> result climbs 0..31, holds 31; up_done=1; sat_hit pulses on cycles 32 and 33.
REQ-034 Scenario: WIDTH=5, WRAP=0; count=1, then 2 cycles of cntD -> result 0, down_done=1; one sat_hit pulse; result stays 0.
REQ-035 Scenario: WIDTH=4, MAX_VAL=9, WRAP=1; count from 0 with cntU for 10 cycles -> result 9 then 0; ovf high for exactly one cycle; cntD at 0 -> result 9 and one unf pulse.
REQ-036 Scenario: same cycle clr=1, load=1, cntU=1 at count 7 -> result 0; load=1 with load_val=15 and MAX_VAL=9 -> result 9.
REQ-037 Scenario: cntU=cntD=1 at count 12 for 3 cycles -> result stays 12; no pulses.
REQ-038 Scenario: rst driven low between clock edges while count=20 -> result=0 immediately; after release, cntU once -> result 1.
